// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: bundles the requester side and the UART TX side of the
// arbiter into one interface.
//   slave  modport : the arbiter (takes req/req_data/tx_done; drives the rest)
//   master modport : clients plus the TX instance / bench
// Signals:
//   req[N_REQ]           byte-pending flag per requester
//   req_data[8*N_REQ]    byte of requester i on bits [8i+7:8i]
//   ack[N_REQ]           one-cycle "byte sent" pulse per requester
//   busy, grant_id       arbiter status
//   tx_d_in, tx_start    to the TX transmitter
//   tx_done              from the TX transmitter
//   err                  one-cycle timeout pulse
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic               busy;
    logic [ID_W-1:0]    grant_id;
    logic [7:0]         tx_d_in;
    logic               tx_start;
    logic               tx_done;
    logic               err;

    modport slave (
        input  req, req_data, tx_done,
        output ack, busy, grant_id, tx_d_in, tx_start, err
    );

    modport master (
        output req, req_data, tx_done,
        input  ack, busy, grant_id, tx_d_in, tx_start, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX transmitter between
// N_REQ byte sources. Runs the tx_start/tx_done handshake: tx_start is held
// until tx_done is seen, and a new start is only issued after tx_done has
// been observed low again.
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high
//   bus     uart_tx_arbiter_if.slave (req, req_data, ack, busy, grant_id,
//           tx_d_in, tx_start, tx_done, err)
// Optional: define TX_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES
// cycles in SEND without tx_done (err pulses, no ack). Without it, err is 0
// and SEND waits for tx_done indefinitely.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_arbiter_if.slave     bus
);

    if (N_REQ < 2 || N_REQ > 8 || ID_W != $clog2(N_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SEND, RELEASE} state_t;

    state_t           state;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  grant_id_r;
    logic [7:0]       tx_d_in_r;
    logic             tx_start_r;
    logic [N_REQ-1:0] ack_r;
    logic             busy_r;
    logic             err_r;
`ifdef TX_TIMEOUT_EN
    logic [31:0]      to_cnt;
`endif

    // Round-robin search starting just after the last served requester.
    // cand carries one extra bit so last_grant + k never wraps before the
    // modulo-N_REQ correction.
    logic             found;
    logic [ID_W-1:0]  pick;
    logic [7:0]       pick_data;
    logic [ID_W:0]    cand;

    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_data = '0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N_REQ))
                cand = cand - (ID_W+1)'(N_REQ);
            if (!found && bus.req[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                pick      = cand[ID_W-1:0];
                pick_data = bus.req_data[{cand[ID_W-1:0], 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            grant_id_r <= '0;
            tx_d_in_r  <= '0;
            tx_start_r <= 1'b0;
            ack_r      <= '0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
`ifdef TX_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            ack_r <= '0;
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        tx_d_in_r  <= pick_data;
                        grant_id_r <= pick;
                        tx_start_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state      <= SEND;
`ifdef TX_TIMEOUT_EN
                        to_cnt     <= '0;
`endif
                    end
                end
                SEND: begin
                    // req/req_data are not looked at here: the latched byte
                    // completes even if the requester withdraws.
                    if (bus.tx_done) begin
                        tx_start_r <= 1'b0;
                        ack_r      <= N_REQ'(1'b1) << grant_id_r;
                        last_grant <= grant_id_r;
                        state      <= RELEASE;
                    end
`ifdef TX_TIMEOUT_EN
                    // Success wins over a timeout in the same cycle.
                    else if (to_cnt + 32'd1 >= 32'(TIMEOUT_CYCLES)) begin
                        tx_start_r <= 1'b0;
                        err_r      <= 1'b1;
                        last_grant <= grant_id_r;
                        state      <= RELEASE;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                    end
`endif
                end
                RELEASE: begin
                    // Wait for tx_done to fall so a stale done is never taken
                    // as completion of the next byte.
                    if (!bus.tx_done) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    tx_start_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack      = ack_r;
    assign bus.busy     = busy_r;
    assign bus.grant_id = grant_id_r;
    assign bus.tx_d_in  = tx_d_in_r;
    assign bus.tx_start = tx_start_r;
    assign bus.err      = err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter. A TX stub
// answers tx_start with a tx_done pulse of configurable latency and length;
// requester models drop or reload their byte on ack. Expected transfer order
// is computed up front from per-requester byte queues by plain round robin.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int         id;
        logic [7:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N), .ID_W(IDW)) bus();

    uart_tx_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    bq_t   src_q[N];
    xfer_t exp_q[$];

    // TX stub and edge-tracking state
    bit stub_en;
    int lat_max, hold_min, hold_max;
    int st_wait, st_lat, st_hold;
    bit st_served;
    bit prev_start, prev_done;

    task automatic do_reset();
        reset        = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_done  = 1'b0;
        stub_en      = 1'b0;
        st_wait = 0; st_lat = 0; st_hold = 0; st_served = 1'b0;
        prev_start = 1'b0; prev_done = 1'b0;
        exp_q.delete();
        for (int i = 0; i < N; i++) src_q[i].delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load_reqs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                bus.req[i] = 1'b1;
                bus.req_data[8*i +: 8] = src_q[i][0];
            end else begin
                bus.req[i] = 1'b0;
            end
        end
    endtask

    // Round robin over the byte queues: every requester with bytes left is
    // pending at each decision, and requester 0 comes first after reset.
    task automatic build_expected();
        bq_t m[N];
        int  last = N - 1;
        int  left = 0;
        for (int i = 0; i < N; i++) begin
            m[i] = src_q[i];
            left += m[i].size();
        end
        while (left > 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (last + k) % N;
                if (m[i].size() > 0) begin
                    exp_q.push_back('{id: i, data: m[i].pop_front()});
                    last = i;
                    left--;
                    break;
                end
            end
        end
    endtask

    task automatic step();
        logic [N-1:0] s_ack;
        logic         s_start, s_done;
        xfer_t        e;
        @(negedge clk);
        s_ack   = bus.ack;
        s_start = bus.tx_start;
        s_done  = bus.tx_done;

        if (s_ack != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_ack: ack=%b with no transfer expected", s_ack);
            end else begin
                e = exp_q.pop_front();
                if (s_ack !== (N'(1) << e.id) || bus.tx_d_in !== e.data || bus.grant_id !== IDW'(e.id)) begin
                    failures++;
                    $display("FAIL xfer: ack=%b byte=%h grant=%0d, expected requester %0d byte %h",
                             s_ack, bus.tx_d_in, bus.grant_id, e.id, e.data);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (s_ack[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    if (src_q[i].size() > 0) bus.req_data[8*i +: 8] = src_q[i][0];
                    else bus.req[i] = 1'b0;
                end
            end
        end

        if (s_start && !prev_start) begin
            checks++;
            if (prev_done) begin
                failures++;
                $display("FAIL start_gap: tx_start rose with tx_done high on the previous cycle");
            end
        end

        if (!s_start) begin
            st_served = 1'b0;
            st_wait   = 0;
        end
        if (st_hold > 0) begin
            st_hold--;
            if (st_hold == 0) bus.tx_done = 1'b0;
        end else if (stub_en && s_start && !st_served) begin
            if (st_wait >= st_lat) begin
                bus.tx_done = 1'b1;
                st_hold     = $urandom_range(hold_max, hold_min);
                st_served   = 1'b1;
                st_lat      = $urandom_range(lat_max, 0);
            end else begin
                st_wait++;
            end
        end

        prev_start = s_start;
        prev_done  = s_done;
    endtask

    task automatic run_xfers(input int budget);
        int cyc    = 0;
        int settle = 0;
        stub_en = 1'b1;
        st_lat  = $urandom_range(lat_max, 0);
        load_reqs();
        while ((exp_q.size() > 0 || settle < 6) && cyc < budget) begin
            step();
            cyc++;
            if (exp_q.size() == 0) settle++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL xfer_count: %0d transfers outstanding after %0d cycles, expected 0",
                     exp_q.size(), cyc);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.req     = '1;
        bus.req_data = '1;
        bus.tx_done = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b0 || bus.tx_d_in !== 8'h00 || bus.ack !== '0 ||
            bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.grant_id !== '0) begin
            failures++;
            $display("FAIL reset_state: start=%b d=%h ack=%b busy=%b err=%b gid=%0d, expected all 0",
                     bus.tx_start, bus.tx_d_in, bus.ack, bus.busy, bus.err, bus.grant_id);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0001;
        bus.req_data[7:0] = 8'h99;
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b1 || bus.tx_d_in !== 8'h99 || bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin
            failures++;
            $display("FAIL single_start: start=%b d=%h busy=%b gid=%0d, expected 1 99 1 0",
                     bus.tx_start, bus.tx_d_in, bus.busy, bus.grant_id);
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0001 || bus.tx_start !== 1'b0) begin
            failures++;
            $display("FAIL single_ack: ack=%b start=%b, expected 0001 0", bus.ack, bus.tx_start);
        end
        bus.req     = '0;
        bus.tx_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0000) begin
            failures++;
            $display("FAIL single_ack_width: ack=%b, expected 0000", bus.ack);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: busy=%b start=%b, expected 0 0", bus.busy, bus.tx_start);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        src_q[0] = '{8'hA0, 8'hA0};
        src_q[1] = '{8'hA1};
        src_q[2] = '{8'hA2};
        src_q[3] = '{8'hA3};
        exp_q = '{'{id: 0, data: 8'hA0}, '{id: 1, data: 8'hA1}, '{id: 2, data: 8'hA2},
                  '{id: 3, data: 8'hA3}, '{id: 0, data: 8'hA0}};
        lat_max = 2; hold_min = 1; hold_max = 2;
        run_xfers(500);
    endtask

    task automatic test_done_hold();
        do_reset();
        src_q[0] = '{8'h11, 8'h12};
        src_q[1] = '{8'h21, 8'h22};
        build_expected();
        lat_max = 1; hold_min = 5; hold_max = 5;
        run_xfers(500);
    endtask

    task automatic test_req_drop_and_reset();
        do_reset();
        bus.req = 4'b0100;
        bus.req_data[23:16] = 8'h5C;
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'd2) begin
            failures++;
            $display("FAIL drop_start: start=%b gid=%0d, expected 1 2", bus.tx_start, bus.grant_id);
        end
        bus.req      = '0;
        bus.req_data = '1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.tx_start !== 1'b1 || bus.tx_d_in !== 8'h5C) begin
                failures++;
                $display("FAIL drop_hold: start=%b d=%h, expected 1 5c", bus.tx_start, bus.tx_d_in);
            end
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0100 || bus.tx_start !== 1'b0) begin
            failures++;
            $display("FAIL drop_ack: ack=%b start=%b, expected 0100 0", bus.ack, bus.tx_start);
        end
        bus.tx_done = 1'b0;
        repeat (2) @(negedge clk);

        bus.req = 4'b0010;
        bus.req_data[15:8] = 8'h33;
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'd1) begin
            failures++;
            $display("FAIL rst_start: start=%b gid=%0d, expected 1 1", bus.tx_start, bus.grant_id);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.ack !== '0) begin
            failures++;
            $display("FAIL rst_mid: start=%b busy=%b ack=%b, expected 0 0 0",
                     bus.tx_start, bus.busy, bus.ack);
        end
        reset   = 1'b0;
        bus.req = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.ack !== '0 || bus.tx_start !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_ack: ack=%b start=%b, expected 0000 0", bus.ack, bus.tx_start);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                int n;
                n = $urandom_range(4, 0);
                for (int b = 0; b < n; b++) src_q[i].push_back(8'($urandom));
            end
            build_expected();
            lat_max = 3; hold_min = 1; hold_max = 3;
            run_xfers(2000);
        end
    endtask

`ifdef TX_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.req = 4'b0011;
        bus.req_data[15:0] = 16'hB2B1;
        @(negedge clk);
        repeat (49) begin
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b0 || bus.tx_start !== 1'b1) begin
                failures++;
                $display("FAIL to_early: err=%b start=%b, expected 0 1", bus.err, bus.tx_start);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b1 || bus.tx_start !== 1'b0 || bus.ack !== '0) begin
            failures++;
            $display("FAIL to_abort: err=%b start=%b ack=%b, expected 1 0 0000",
                     bus.err, bus.tx_start, bus.ack);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'd1 || bus.tx_d_in !== 8'hB2) begin
            failures++;
            $display("FAIL to_next: start=%b gid=%0d d=%h, expected 1 1 b2",
                     bus.tx_start, bus.grant_id, bus.tx_d_in);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_done_hold();
        test_req_drop_and_reset();
        test_random();
`ifdef TX_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
